// File: rtl/pixel_shuffle_seq.sv
// pixel_shuffle_seq: streams a depth-to-space shuffle of a channel-major tensor held in a
// synchronous-read buffer, as a raster-order valid/ready pixel stream through a 4-deep FIFO.
module pixel_shuffle_seq #(
    parameter int C          = 1,
    parameter int R          = 2,
    parameter int H          = 2,
    parameter int W          = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);
    localparam logic [ADDR_WIDTH-1:0] CA = ADDR_WIDTH'(C);
    localparam logic [ADDR_WIDTH-1:0] RA = ADDR_WIDTH'(R);
    localparam logic [ADDR_WIDTH-1:0] HA = ADDR_WIDTH'(H);
    localparam logic [ADDR_WIDTH-1:0] WA = ADDR_WIDTH'(W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_n;

    logic [ADDR_WIDTH-1:0] c, h, r1, w, r2, addr;
    logic                  at_c, at_h, at_r1, at_w, at_r2, last_pix;
    logic                  issue, pend, rd_last, pend_last, push, pop;
    logic [DATA_WIDTH:0]   mem [4];
    logic [1:0]            wp, rp;
    logic [2:0]            cnt;
    logic [3:0]            reserved;

    assign at_r2    = r2 == RA - 1'b1;
    assign at_w     = w == WA - 1'b1;
    assign at_r1    = r1 == RA - 1'b1;
    assign at_h     = h == HA - 1'b1;
    assign at_c     = c == CA - 1'b1;
    assign last_pix = at_c & at_h & at_r1 & at_w & at_r2;
    assign addr     = ((c * RA * RA + r1 * RA + r2) * HA + h) * WA + w;

    assign out_valid = cnt != 3'd0;
    assign out_data  = out_valid ? mem[rp][DATA_WIDTH-1:0] : '0;
    assign out_last  = out_valid & mem[rp][DATA_WIDTH];
    assign pop       = out_valid & out_ready;
    assign push      = pend;
    // Slots already promised: queued beats plus reads still in the buffer pipeline, net of this pop.
    assign reserved  = {1'b0, cnt} + {3'b0, rd_en} + {3'b0, pend} - {3'b0, pop};
    assign busy      = state == S_RUN || state == S_DRAIN;
    assign done      = state == S_DONE;

    always_ff @(posedge clk)
        state <= rst ? S_IDLE : state_n;

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                issue   = 1'b1;
                state_n = last_pix ? S_DRAIN : S_RUN;
            end
            S_RUN: if (reserved < 4'd4) begin
                issue   = 1'b1;
                state_n = last_pix ? S_DRAIN : S_RUN;
            end
            S_DRAIN: state_n = (pop && out_last) ? S_DONE : S_DRAIN;
            default: state_n = S_IDLE;
        endcase
    end

    // Counters point at the next pixel to read; a finished job wraps them all back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            {c, h, r1, w, r2} <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            rd_last   <= 1'b0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
        end else begin
            rd_en     <= issue;
            rd_last   <= issue & last_pix;
            pend      <= rd_en;
            pend_last <= rd_last;
            if (issue) begin
                rd_addr <= addr;
                r2 <= at_r2 ? '0 : r2 + 1'b1;
                w  <= at_r2 ? (at_w ? '0 : w + 1'b1) : w;
                r1 <= (at_r2 && at_w) ? (at_r1 ? '0 : r1 + 1'b1) : r1;
                h  <= (at_r2 && at_w && at_r1) ? (at_h ? '0 : h + 1'b1) : h;
                c  <= (at_r2 && at_w && at_r1 && at_h) ? (at_c ? '0 : c + 1'b1) : c;
            end
            if (push) begin
                mem[wp] <= {pend_last, rd_data};
                wp      <= wp + 1'b1;
            end
            if (pop)
                rp <= rp + 1'b1;
            cnt <= cnt + {2'b0, push} - {2'b0, pop};
        end
    end
endmodule

// File: tb/tb_pixel_shuffle_seq.sv
// tb_pixel_shuffle_seq: directed bench for pixel_shuffle_seq with a raster-coordinate
// reference model, per-cycle stream/credit monitor and a second identity-shape instance.
module tb_pixel_shuffle_seq;
    localparam int N  = 16;
    localparam int NB = 18;
    localparam int PC = 1, PR = 2, PH = 2, PW = 2;

    logic        clk = 0, rst = 1, start = 0, out_ready = 0;
    logic        busy, done, rd_en, out_valid, out_last;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data = 0, out_data;

    logic        b_start = 0, b_ready = 1;
    logic        b_busy, b_done, b_rd_en, b_valid, b_last;
    logic [15:0] b_rd_addr;
    logic [7:0]  b_rd_data = 0, b_data;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, rd_idx = 0, beat_idx = 0, dones = 0;
    int first_cyc = 0, last_cyc = 0, done_cyc = 0;
    logic       prev_stall = 0;
    logic [7:0] prev_data = 0;
    int got_q[$];
    int lit[16] = '{0, 4, 1, 5, 8, 12, 9, 13, 2, 6, 3, 7, 10, 14, 11, 15};

    pixel_shuffle_seq dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    pixel_shuffle_seq #(.C(2), .R(3), .H(1), .W(1)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data), .out_last(b_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    // Buffers hold value = address.
    always @(posedge clk) if (rd_en) rd_data <= rd_addr[7:0];
    always @(posedge clk) if (b_rd_en) b_rd_data <= b_rd_addr[7:0];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Output beat k sits at raster (y, x) of channel c; invert the depth-to-space mapping.
    function automatic int exp_addr(input int k);
        int ow, oh, c, y, x;
        if (k >= N) return -1;
        ow = PW * PR;
        oh = PH * PR;
        c  = k / (oh * ow);
        y  = (k / ow) % oh;
        x  = k % ow;
        return ((c * PR * PR + (y % PR) * PR + x % PR) * PH + y / PR) * PW + x / PR;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            rd_idx = 0;
            beat_idx = 0;
            prev_stall = 0;
            got_q.delete();
        end else begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (rd_en) begin
                chk("rd_addr", rd_addr, exp_addr(rd_idx));
                rd_idx++;
            end
            chk("credit", rd_idx - beat_idx <= 4, 1);
            if (out_valid && out_ready) begin
                chk("beat_data", out_data, exp_addr(beat_idx) & 'hff);
                chk("beat_last", out_last, beat_idx == N - 1);
                if (beat_idx == 0) first_cyc = cyc;
                last_cyc = cyc;
                got_q.push_back(int'(out_data));
                beat_idx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            if (done) begin
                chk("done_beats", beat_idx, N);
                chk("done_busy", busy, 0);
                done_cyc = cyc;
                dones++;
                rd_idx = 0;
                beat_idx = 0;
            end
        end
    end

    task automatic go();
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input bit rnd);
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        chk("done_seen", done, 1);
    endtask

    task automatic check_seq();
        chk("seq_len", got_q.size(), N);
        for (int i = 0; i < N && i < got_q.size(); i++) chk("seq", got_q[i], lit[i]);
        got_q.delete();
    endtask

    initial begin
        int d0, bi;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        rst = 0;
        @(posedge clk); #1;

        // Basic run with latency, bubble-free streaming and done timing.
        out_ready = 1;
        go();
        chk("e0_busy", busy, 1);
        chk("e0_rd_en", rd_en, 1);
        chk("e0_rd_addr", rd_addr, 0);
        chk("e0_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("e1_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("e2_valid", out_valid, 1);
        chk("e2_data", out_data, 0);
        wait_done(0);
        @(posedge clk); #1;
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("done_gap", done_cyc - last_cyc, 1);
        chk("no_bubbles", last_cyc - first_cyc, N - 1);
        chk("dones_basic", dones, 1);
        check_seq();

        // Random backpressure.
        go();
        wait_done(1);
        out_ready = 1;
        @(posedge clk); #1;
        check_seq();

        // Full stall then release.
        out_ready = 0;
        go();
        repeat (10) @(posedge clk);
        #1;
        chk("stall_reads", rd_idx, 4);
        chk("stall_rd_en", rd_en, 0);
        chk("stall_head_valid", out_valid, 1);
        chk("stall_head_data", out_data, 0);
        chk("stall_head_last", out_last, 0);
        out_ready = 1;
        wait_done(0);
        @(posedge clk); #1;
        check_seq();

        // Start during RUN and in the DONE cycle must be ignored.
        d0 = dones;
        go();
        repeat (4) @(posedge clk);
        #1;
        go();
        wait_done(0);
        go();
        chk("ign_done", done, 0);
        chk("ign_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("ign_busy_later", busy, 0);
        chk("ign_rd_en", rd_en, 0);
        chk("ign_single_done", dones - d0, 1);
        check_seq();
        go();
        wait_done(0);
        @(posedge clk); #1;
        check_seq();

        // Reset mid-run after 5 beats.
        go();
        for (int i = 0; i < 50 && beat_idx < 5; i++) begin
            @(posedge clk); #1;
        end
        chk("mid_beats", beat_idx, 5);
        rst = 1;
        @(posedge clk); #1;
        chk("mr_busy", busy, 0);
        chk("mr_valid", out_valid, 0);
        chk("mr_rd_en", rd_en, 0);
        chk("mr_rd_addr", rd_addr, 0);
        chk("mr_done", done, 0);
        rst = 0;
        @(posedge clk); #1;
        go();
        wait_done(0);
        @(posedge clk); #1;
        check_seq();

        // Identity shape C=2 R=3 H=1 W=1: beats are 0..17 in order.
        b_start = 1;
        @(posedge clk); #1;
        b_start = 0;
        bi = 0;
        for (int i = 0; i < 60 && bi < NB; i++) begin
            @(negedge clk);
            if (b_valid && b_ready) begin
                chk("id_data", b_data, bi);
                chk("id_last", b_last, bi == NB - 1);
                bi++;
            end
        end
        chk("id_beats", bi, NB);
        @(posedge clk); #1;
        chk("id_done", b_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
